// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and halt sequencing for the 5-stage pipeline.
// Drives register enables/clears, EX forwarding selects and statistics.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        ID_Jump,
    input  logic [4:0]  EX_Rs,
    input  logic [4:0]  EX_Rt,
    input  logic [4:0]  EX_WAdr,
    input  logic        EX_RegWrite,
    input  logic        EX_MemToReg,
    input  logic        EX_BranchTaken,
    input  logic [4:0]  MEM_WAdr,
    input  logic        MEM_RegWrite,
    input  logic        MEM_Syscall,
    input  logic        MEM_HaltReq,
    input  logic [4:0]  WB_WAdr,
    input  logic        WB_RegWrite,
    input  logic        Go,
    output logic        PC_En,
    output logic        IF_ID_En,
    output logic        IF_ID_CLR,
    output logic        ID_EX_CLR,
    output logic        EX_MEM_CLR,
    output logic [1:0]  Fwd_A,
    output logic [1:0]  Fwd_B,
    output logic        Resume_PCSel,
    output logic        Halted,
    output logic [31:0] CycleCnt,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  drain_q;
    logic [2:0]  drain_nx;
    logic [31:0] cycle_q;
    logic [15:0] stall_q;
    logic [15:0] flush_q;
    logic        load_use;
    logic        halt_hit;
    logic        do_stall;
    logic        do_flush;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_wadr,
        input logic       mem_rw,
        input logic [4:0] wb_wadr,
        input logic       wb_rw
    );
        if (mem_rw && mem_wadr != 5'd0 && mem_wadr == src)
            return 2'b01;
        else if (wb_rw && wb_wadr != 5'd0 && wb_wadr == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Hazard detection: a load in EX feeding a register read in ID
    always_comb begin
        load_use = EX_MemToReg && EX_RegWrite && (EX_WAdr != 5'd0) &&
                   ((ID_UseRs && ID_Rs == EX_WAdr) ||
                    (ID_UseRt && ID_Rt == EX_WAdr));
        halt_hit = (state == S_RUN) && MEM_Syscall && MEM_HaltReq;
    end

    // Pipeline control, forwarding and next-state selection
    always_comb begin
        PC_En        = 1'b0;
        IF_ID_En     = 1'b0;
        IF_ID_CLR    = 1'b1;
        ID_EX_CLR    = 1'b1;
        EX_MEM_CLR   = 1'b1;
        Fwd_A        = 2'b00;
        Fwd_B        = 2'b00;
        Resume_PCSel = 1'b0;
        Halted       = 1'b0;
        state_nx     = state;
        drain_nx     = drain_q;
        do_stall     = 1'b0;
        do_flush     = 1'b0;
        if (!CLR) begin
            Fwd_A = fwd_sel(EX_Rs, MEM_WAdr, MEM_RegWrite,
                            WB_WAdr, WB_RegWrite);
            Fwd_B = fwd_sel(EX_Rt, MEM_WAdr, MEM_RegWrite,
                            WB_WAdr, WB_RegWrite);
            unique case (state)
                S_RUN: begin
                    IF_ID_CLR  = 1'b0;
                    ID_EX_CLR  = 1'b0;
                    EX_MEM_CLR = 1'b0;
                    if (halt_hit) begin
                        IF_ID_CLR  = 1'b1;
                        ID_EX_CLR  = 1'b1;
                        EX_MEM_CLR = 1'b1;
                        state_nx   = S_DRAIN;
                        drain_nx   = DRAIN_INIT;
                    end else if (EX_BranchTaken) begin
                        PC_En     = 1'b1;
                        IF_ID_En  = 1'b1;
                        IF_ID_CLR = 1'b1;
                        ID_EX_CLR = 1'b1;
                        do_flush  = 1'b1;
                    end else if (load_use) begin
                        ID_EX_CLR = 1'b1;
                        do_stall  = 1'b1;
                    end else if (ID_Jump) begin
                        PC_En     = 1'b1;
                        IF_ID_En  = 1'b1;
                        IF_ID_CLR = 1'b1;
                    end else begin
                        PC_En    = 1'b1;
                        IF_ID_En = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q <= 3'd1) begin
                        state_nx = S_HALTED;
                        drain_nx = 3'd0;
                    end else begin
                        drain_nx = drain_q - 3'd1;
                    end
                end
                S_HALTED: begin
                    Halted = 1'b1;
                    if (Go) begin
                        Resume_PCSel = 1'b1;
                        PC_En        = 1'b1;
                        state_nx     = S_RUN;
                    end
                end
                default: state_nx = S_RUN;
            endcase
        end
    end

    // State, drain counter and statistics registers
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state   <= S_RUN;
            drain_q <= 3'd0;
            cycle_q <= 32'd0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state   <= state_nx;
            drain_q <= drain_nx;
            if (state != S_HALTED)
                cycle_q <= cycle_q + 32'd1;
            if (do_stall && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (do_flush && flush_q != 16'hFFFF)
                flush_q <= flush_q + 16'd1;
        end
    end

    assign CycleCnt = cycle_q;
    assign StallCnt = stall_q;
    assign FlushCnt = flush_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Each cycle it computes the PC and IF/ID enables, the synchronous clears for the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX-stage operand forwarding selects. A state machine stops the pipeline when a halt syscall reaches MEM and restarts it on a Go pulse. It also keeps cycle, stall and flush statistics counters.

## Interface
- DRAIN_CYCLES, default 1: cycles spent in DRAIN before HALTED. Legal range is 1–7.
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- ID_Rs, ID_Rt  in  5 each  source register addresses of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1 each  the ID instruction actually reads that register.
- ID_Jump  in  1  an unconditional jump is decoded in ID.
- EX_Rs, EX_Rt  in  5 each  source register addresses of the instruction in EX.
- EX_WAdr  in  5  destination register of the instruction in EX.
- EX_RegWrite, EX_MemToReg  in  1 each  control bits of the instruction in EX.
- EX_BranchTaken  in  1  the branch resolved in EX is taken.
- MEM_WAdr, MEM_RegWrite  in  5 / 1  EX/MEM register outputs.
- MEM_Syscall, MEM_HaltReq  in  1 each  a syscall is in MEM; the syscall service code requests a halt.
- WB_WAdr, WB_RegWrite  in  5 / 1  MEM/WB register outputs.
- Go  in  1  resume pulse; honoured only in HALTED.
- PC_En, IF_ID_En  out  1 each  register load enables.
- IF_ID_CLR, ID_EX_CLR, EX_MEM_CLR  out  1 each  synchronous clears; each loads zero (a bubble) at the next edge.
- Fwd_A, Fwd_B  out  2 each  ALU operand select: 00 = register file, 01 = EX/MEM ALU result, 10 = WB data.
- Resume_PCSel  out  1  the datapath loads PC from the captured syscall PC+4.
- Halted  out  1  FSM is in HALTED.
- CycleCnt  out  32  counts cycles spent in RUN or DRAIN.
- StallCnt, FlushCnt  out  16 each  load-use stall cycles and taken-branch flushes.

## Operation
- FSM states are RUN, DRAIN and HALTED. The reset state is RUN.
- Load-use hazard is true when all of the following hold:
  - EX_MemToReg, EX_RegWrite and EX_WAdr≠0;
  - (ID_UseRs and ID_Rs=EX_WAdr) or (ID_UseRt and ID_Rt=EX_WAdr).
- Halt hit is true when the FSM is in RUN and MEM_Syscall and MEM_HaltReq are both high.
- RUN priority, highest first:
  1. Halt hit: PC_En=0, IF_ID_En=0, IF_ID_CLR=1, ID_EX_CLR=1, EX_MEM_CLR=1. Next state is DRAIN and the drain counter loads DRAIN_CYCLES.
  2. EX_BranchTaken: PC_En=1, IF_ID_En=1, IF_ID_CLR=1, ID_EX_CLR=1. Any load-use hazard and ID_Jump are ignored, because those instructions are on the wrong path. FlushCnt increments.
  3. Load-use hazard: PC_En=0, IF_ID_En=0, ID_EX_CLR=1. StallCnt increments. If ID_Jump is also high, the jump waits.
  4. ID_Jump: IF_ID_CLR=1, with PC_En=1 and IF_ID_En=1.
  5. Otherwise PC_En=1, IF_ID_En=1 and all clears are 0.
- DRAIN: PC_En=0, IF_ID_En=0 and all three clears are 1. The drain counter decrements each cycle; when it reaches 1, the next state is HALTED.
- HALTED: enables 0, clears 1, Halted=1, CycleCnt holds. When Go=1, Resume_PCSel=1 for that cycle, PC_En=1, and the next state is RUN.
- Go is ignored in RUN and DRAIN.
- Forwarding applies to Fwd_A (using EX_Rs) and Fwd_B (using EX_Rt) independently:
  - 01 if MEM_RegWrite, MEM_WAdr≠0 and MEM_WAdr matches;
  - otherwise 10 if WB_RegWrite, WB_WAdr≠0 and WB_WAdr matches;
  - otherwise 00.
  - Forwarding is evaluated in every state.
- Counters:
  - CycleCnt wraps modulo 2^32.
  - StallCnt and FlushCnt saturate at 0xFFFF.
  - All counters are cleared only by CLR.

## Timing
- All enables, clears, forwarding selects and Resume_PCSel are combinational from the current inputs and state, settling within the same cycle. They take effect at the next CLK edge.
- The FSM state, drain counter and statistics counters are registered.
- A load-use hazard costs exactly 1 bubble. On the following cycle the load is in MEM, and Fwd supplies the data from WB one cycle later.
- A taken branch costs 2 flushed slots. A jump costs 1.
- Halt hit to Halted=1 takes DRAIN_CYCLES+1 edges.
- While CLR is high:
  - state=RUN and the drain counter is 0;
  - counters are 0;
  - PC_En=0, IF_ID_En=0;
  - IF_ID_CLR=1, ID_EX_CLR=1, EX_MEM_CLR=1;
  - Fwd_A=Fwd_B=00, Resume_PCSel=0, Halted=0.
- CLR asserted in the middle of DRAIN or HALTED returns the block to RUN on release, with no resume pulse.

## Test plan
- Load-use stall: lw with EX_WAdr=8, then the ID instruction reads rs=8 (ID_UseRs=1). Expect 1 cycle of PC_En=0 and ID_EX_CLR=1, then Fwd_A=10 two cycles later, and StallCnt=1. Repeat with EX_WAdr=0 and expect no stall.
- Forward priority: MEM_WAdr=WB_WAdr=EX_Rt=5 with both RegWrite bits set. Expect Fwd_B=01. Drop MEM_RegWrite and expect Fwd_B=10.
- Branch beats stall and jump: EX_BranchTaken=1 together with a load-use hazard and ID_Jump. Expect PC_En=1, IF_ID_CLR=1, ID_EX_CLR=1, FlushCnt+1 and StallCnt unchanged.
- Halt sequence with DRAIN_CYCLES=2: raise MEM_Syscall and MEM_HaltReq. Expect EX_MEM_CLR=1 immediately and Halted=1 after 3 edges, with CycleCnt frozen. A Go pulse gives Resume_PCSel=1 for 1 cycle, then RUN.
- Saturation and wrap: preload StallCnt to 0xFFFE via forced stalls and apply 3 more stalls; expect 0xFFFF. Force CycleCnt to 0xFFFFFFFF and tick once; expect 0.
- Reset mid-DRAIN: assert CLR asynchronously between edges. Expect all outputs at their reset values immediately, and RUN with counters at 0 after release.
